// File: rtl/sram_access_arbiter_if.sv
// Bundle of the two requester handshakes and the SRAM wrapper pins.
// The arbiter uses the slave view; clients and the SRAM model use the master view.
interface sram_access_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 128
);
  logic                  req0;
  logic                  we0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] wdata0;
  logic                  ack0;
  logic [DATA_WIDTH-1:0] rdata0;

  logic                  req1;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  ack1;
  logic [DATA_WIDTH-1:0] rdata1;

  logic                  sram_read_enable;
  logic                  sram_write_enable;
  logic [ADDR_WIDTH-1:0] sram_address;
  logic [DATA_WIDTH-1:0] sram_write_data;
  logic [DATA_WIDTH-1:0] sram_read_data;

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    input  ack0, rdata0, ack1, rdata1,
    input  sram_read_enable, sram_write_enable, sram_address, sram_write_data,
    output sram_read_data
  );

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    output ack0, rdata0, ack1, rdata1,
    output sram_read_enable, sram_write_enable, sram_address, sram_write_data,
    input  sram_read_data
  );
endinterface

// File: rtl/sram_access_arbiter.sv
// Round-robin two-client front end for the on-chip SRAM wrapper: latches the
// winning request, holds the enables for ACCESS_CYCLES, then acks the owner.
module sram_access_arbiter #(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 128,
  parameter int ACCESS_CYCLES = 2
) (
  input logic                clk,
  input logic                rst,
  sram_access_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    COMPLETE = 2'd2
  } state_t;

  localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

  state_t                state, state_next;
  logic                  owner;
  logic                  last_grant;
  logic                  we_lat;
  logic [ADDR_WIDTH-1:0] addr_lat;
  logic [DATA_WIDTH-1:0] wdata_lat;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] rdata0_q;
  logic [DATA_WIDTH-1:0] rdata1_q;
  logic                  grant_valid;
  logic                  grant_id;

  // Arbitration and next state. On a tie the requester that did not win last
  // time gets the slot, so continuous requesters strictly alternate.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    state_next  = state;
    unique case (state)
      IDLE: begin
        if (bus.req0 && bus.req1) begin
          grant_valid = 1'b1;
          grant_id    = ~last_grant;
        end else if (bus.req0) begin
          grant_valid = 1'b1;
          grant_id    = 1'b0;
        end else if (bus.req1) begin
          grant_valid = 1'b1;
          grant_id    = 1'b1;
        end
        if (grant_valid) state_next = ACCESS;
      end
      ACCESS:   if (cnt == '0) state_next = COMPLETE;
      COMPLETE: state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Outputs decode the registered state only, so an async reset drops the
  // enables and acks without waiting for a clock edge.
  always_comb begin
    bus.sram_read_enable  = 1'b0;
    bus.sram_write_enable = 1'b0;
    bus.sram_address      = '0;
    bus.sram_write_data   = '0;
    bus.ack0              = 1'b0;
    bus.ack1              = 1'b0;
    unique case (state)
      ACCESS: begin
        bus.sram_read_enable  = ~we_lat;
        bus.sram_write_enable = we_lat;
        bus.sram_address      = addr_lat;
        bus.sram_write_data   = wdata_lat;
      end
      COMPLETE: begin
        bus.ack0 = ~owner;
        bus.ack1 = owner;
      end
      default: ;
    endcase
  end

  assign bus.rdata0 = rdata0_q;
  assign bus.rdata1 = rdata1_q;

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // here samples the pre-edge values, independent of statement order.
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      we_lat     <= 1'b0;
      addr_lat   <= '0;
      wdata_lat  <= '0;
      cnt        <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state <= state_next;
      unique case (state)
        IDLE: begin
          if (grant_valid) begin
            owner     <= grant_id;
            we_lat    <= grant_id ? bus.we1    : bus.we0;
            addr_lat  <= grant_id ? bus.addr1  : bus.addr0;
            wdata_lat <= grant_id ? bus.wdata1 : bus.wdata0;
            cnt       <= CNT_LOAD;
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (!we_lat) begin
            // Last enable cycle of a read: the SRAM output has settled.
            if (owner) rdata1_q <= bus.sram_read_data;
            else       rdata0_q <= bus.sram_read_data;
          end
        end
        COMPLETE: last_grant <= owner;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed bench for sram_access_arbiter: a behavioural SRAM answers both a
// 2-cycle build and a 1-cycle build; each scenario checks its own results.
module tb_sram_access_arbiter;

  localparam int AW = 16;
  localparam int DW = 128;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  sram_access_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus  ();
  sram_access_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

  sram_access_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ACCESS_CYCLES(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  sram_access_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ACCESS_CYCLES(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  // Power-on contents of the SRAM model.
  function automatic logic [DW-1:0] pre(input logic [AW-1:0] a);
    if (a == 16'h0010) return 128'h00112233445566778899AABBCCDDEEFF;
    return {8{a ^ 16'h5A5A}};
  endfunction

  logic [DW-1:0] mem [0:65535];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 65536; i++) mem[i] <= pre(16'(i));
    end else if (bus.sram_write_enable) begin
      mem[bus.sram_address] <= bus.sram_write_data;
    end
  end

  assign bus.sram_read_data  = mem[bus.sram_address];
  assign bus1.sram_read_data = mem[bus1.sram_address];

  task automatic clear_inputs();
    bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
    bus1.req0 = 0; bus1.we0 = 0; bus1.addr0 = '0; bus1.wdata0 = '0;
    bus1.req1 = 0; bus1.we1 = 0; bus1.addr1 = '0; bus1.wdata1 = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs one access on the 2-cycle DUT and reports what the pins did.
  task automatic access(input bit p, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit swap, input logic [AW-1:0] swap_a,
                        output int en_cnt, output int ack_at, output int bus_bad,
                        output int other_ack);
    en_cnt = 0; ack_at = -1; bus_bad = 0; other_ack = 0;
    @(negedge clk);
    if (!p) begin bus.req0 = 1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d; end
    else    begin bus.req1 = 1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d; end
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.sram_read_enable && bus.sram_write_enable) bus_bad++;
      if (bus.sram_read_enable || bus.sram_write_enable) begin
        en_cnt++;
        if (bus.sram_address !== a || bus.sram_write_enable !== we) bus_bad++;
        if (we && bus.sram_write_data !== d) bus_bad++;
      end
      if (p ? bus.ack0 : bus.ack1) other_ack++;
      if (swap && c == 1) begin
        if (!p) bus.addr0 = swap_a; else bus.addr1 = swap_a;
      end
      if (p ? bus.ack1 : bus.ack0) begin
        ack_at = c;
        break;
      end
    end
    if (!p) bus.req0 = 0; else bus.req1 = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    #1 rst = 1'b1;
    #12;
    n_cmp++;
    if ({bus.ack0, bus.ack1, bus.sram_read_enable, bus.sram_write_enable} !== 4'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b expected 0000",
        {bus.ack0, bus.ack1, bus.sram_read_enable, bus.sram_write_enable});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.ack0, bus.ack1, bus.sram_read_enable, bus.sram_write_enable} !== 4'b0) begin
      n_err++; $display("FAIL idle_ctrl: got %b expected 0000",
        {bus.ack0, bus.ack1, bus.sram_read_enable, bus.sram_write_enable});
    end
    n_cmp++;
    if (bus.sram_address !== '0 || bus.sram_write_data !== '0) begin
      n_err++; $display("FAIL idle_bus: got addr %h data %h expected 0", bus.sram_address,
        bus.sram_write_data);
    end
    n_cmp++;
    if (bus.rdata0 !== '0 || bus.rdata1 !== '0) begin
      n_err++; $display("FAIL reset_rdata: got %h / %h expected 0", bus.rdata0, bus.rdata1);
    end
  endtask

  task automatic test_read0();
    int en, ack, bad, oth;
    access(0, 0, 16'h0010, '0, 0, '0, en, ack, bad, oth);
    n_cmp++;
    if (en !== 2) begin n_err++; $display("FAIL t1_en_cycles: got %0d expected 2", en); end
    n_cmp++;
    if (ack !== 3) begin n_err++; $display("FAIL t1_ack_cycle: got %0d expected 3", ack); end
    n_cmp++;
    if (bus.rdata0 !== 128'h00112233445566778899AABBCCDDEEFF) begin
      n_err++; $display("FAIL t1_rdata0: got %h expected 00112233445566778899aabbccddeeff",
        bus.rdata0);
    end
    n_cmp++;
    if (bad !== 0 || oth !== 0) begin
      n_err++; $display("FAIL t1_bus: got bad=%0d ack1=%0d expected 0/0", bad, oth);
    end
  endtask

  task automatic test_write_read1();
    int en, ack, bad, oth;
    access(1, 1, 16'hFFFF, {16{8'hA5}}, 0, '0, en, ack, bad, oth);
    n_cmp++;
    if (en !== 2 || ack !== 3) begin
      n_err++; $display("FAIL t2_write_timing: got en=%0d ack=%0d expected 2/3", en, ack);
    end
    n_cmp++;
    if (bad !== 0 || oth !== 0) begin
      n_err++; $display("FAIL t2_write_bus: got bad=%0d ack0=%0d expected 0/0", bad, oth);
    end
    n_cmp++;
    if (bus.rdata1 !== '0) begin
      n_err++; $display("FAIL t2_rdata1_after_write: got %h expected 0", bus.rdata1);
    end
    access(1, 0, 16'hFFFF, '0, 0, '0, en, ack, bad, oth);
    n_cmp++;
    if (en !== 2 || ack !== 3 || bad !== 0) begin
      n_err++; $display("FAIL t2_read_timing: got en=%0d ack=%0d bad=%0d expected 2/3/0",
        en, ack, bad);
    end
    n_cmp++;
    if (bus.rdata1 !== {16{8'hA5}}) begin
      n_err++; $display("FAIL t2_rdata1: got %h expected a5 x16", bus.rdata1);
    end
    n_cmp++;
    if (bus.rdata0 !== 128'h00112233445566778899AABBCCDDEEFF) begin
      n_err++; $display("FAIL t2_rdata0_held: got %h expected 0011..eeff", bus.rdata0);
    end
  endtask

  task automatic test_fairness();
    int n = 0;
    int ovl = 0;
    int order [4];
    int ack_c [4];
    do_reset();
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 16'h0020;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 16'h0021;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.ack0 && bus.ack1) ovl++;
      if (bus.sram_read_enable && bus.sram_write_enable) ovl++;
      if (bus.ack0 || bus.ack1) begin
        order[n] = bus.ack1 ? 1 : 0;
        ack_c[n] = c;
        n++;
        if (n == 4) break;
      end
    end
    bus.req0 = 0; bus.req1 = 0;
    n_cmp++;
    if (n !== 4) begin n_err++; $display("FAIL t3_ack_count: got %0d expected 4", n); end
    for (int i = 0; i < n; i++) begin
      n_cmp++;
      if (order[i] !== (i % 2) || ack_c[i] !== 3 + 4 * i) begin
        n_err++; $display("FAIL t3_grant_%0d: got req%0d at cycle %0d expected req%0d at %0d",
          i, order[i], ack_c[i], i % 2, 3 + 4 * i);
      end
    end
    n_cmp++;
    if (ovl !== 0) begin n_err++; $display("FAIL t3_overlap: got %0d expected 0", ovl); end
    n_cmp++;
    if (bus.rdata0 !== pre(16'h0020) || bus.rdata1 !== pre(16'h0021)) begin
      n_err++; $display("FAIL t3_rdata: got %h / %h expected %h / %h", bus.rdata0, bus.rdata1,
        pre(16'h0020), pre(16'h0021));
    end
  endtask

  task automatic test_addr_latch();
    int en, ack, bad, oth;
    access(0, 0, 16'h0100, '0, 1, 16'h0200, en, ack, bad, oth);
    n_cmp++;
    if (en !== 2 || ack !== 3 || bad !== 0) begin
      n_err++; $display("FAIL t4_latched_addr: got en=%0d ack=%0d bad=%0d expected 2/3/0",
        en, ack, bad);
    end
    n_cmp++;
    if (bus.rdata0 !== pre(16'h0100)) begin
      n_err++; $display("FAIL t4_rdata0: got %h expected %h", bus.rdata0, pre(16'h0100));
    end
  endtask

  task automatic test_reset_mid_access();
    int en, ack, bad, oth;
    int ack_seen = 0;
    @(negedge clk);
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 16'h0300; bus.wdata0 = {8{16'hBEEF}};
    @(negedge clk);
    n_cmp++;
    if (bus.sram_write_enable !== 1'b1) begin
      n_err++; $display("FAIL t5_write_started: got %b expected 1", bus.sram_write_enable);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.sram_read_enable, bus.sram_write_enable, bus.ack0, bus.ack1} !== 4'b0) begin
      n_err++; $display("FAIL t5_async_drop: got %b expected 0000",
        {bus.sram_read_enable, bus.sram_write_enable, bus.ack0, bus.ack1});
    end
    bus.req0 = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 2) rst = 1'b0;
      if (bus.ack0 || bus.ack1) ack_seen++;
    end
    n_cmp++;
    if (ack_seen !== 0 || bus.sram_write_enable !== 1'b0 || bus.sram_read_enable !== 1'b0) begin
      n_err++; $display("FAIL t5_abandoned: got acks=%0d we=%b re=%b expected 0/0/0", ack_seen,
        bus.sram_write_enable, bus.sram_read_enable);
    end
    access(0, 0, 16'h0010, '0, 0, '0, en, ack, bad, oth);
    n_cmp++;
    if (en !== 2 || ack !== 3 || bus.rdata0 !== pre(16'h0010)) begin
      n_err++; $display("FAIL t5_recover: got en=%0d ack=%0d rdata0=%h expected 2/3/%h", en, ack,
        bus.rdata0, pre(16'h0010));
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int en = 0;
    int ack_c [2];
    logic [DW-1:0] got [2];
    @(negedge clk);
    bus1.req0 = 1; bus1.we0 = 0; bus1.addr0 = 16'h0001;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus1.sram_read_enable || bus1.sram_write_enable) en++;
      if (bus1.ack0) begin
        ack_c[n] = c;
        got[n]   = bus1.rdata0;
        n++;
        if (n == 2) break;
        bus1.addr0 = 16'h0002;
      end
    end
    bus1.req0 = 0;
    n_cmp++;
    if (n !== 2 || ack_c[0] !== 2 || ack_c[1] !== 5) begin
      n_err++; $display("FAIL t6_ack_cycles: got n=%0d at %0d,%0d expected 2 at 2,5", n,
        ack_c[0], ack_c[1]);
    end
    n_cmp++;
    if (en !== 2) begin n_err++; $display("FAIL t6_en_cycles: got %0d expected 2", en); end
    n_cmp++;
    if (got[0] !== pre(16'h0001) || got[1] !== pre(16'h0002)) begin
      n_err++; $display("FAIL t6_rdata: got %h,%h expected %h,%h", got[0], got[1],
        pre(16'h0001), pre(16'h0002));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_read0();
    test_write_read1();
    test_fairness();
    test_addr_latch();
    test_reset_mid_access();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
